// File: rtl/ksa_pipe.sv
// rtl/ksa_pipe.sv - pipelined Kogge-Stone adder/subtractor with valid/ready handshake
//
// Purpose:
//   Registered propagate/generate stage, one register per Kogge-Stone prefix
//   level, and a registered sum stage (WIDTH operands, L = $clog2(WIDTH)
//   prefix levels, L+2 register stages total). One result per cycle while the
//   consumer is ready; a single global stall freezes every stage.
//
// Optional feature macro: KSA_PIPE_OVF_EN (adds the ovf port and its logic).
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands present
//   in_ready   block can accept operands this cycle
//   a, b       operands (WIDTH bits)
//   cin        carry-in (ignored when sub=1)
//   sub        0: a+b+cin, 1: a-b
//   out_valid  result present
//   out_ready  consumer accepts result
//   sum        result (WIDTH bits)
//   cout       carry out of MSB (for sub, 1 = no borrow)
//   ovf        signed overflow (only with KSA_PIPE_OVF_EN)

module ksa_pipe #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef KSA_PIPE_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int L = $clog2(WIDTH);

    // Stage k (0..L) registers: group generate/propagate, raw bitwise
    // propagate and effective carry-in carried along for the sum stage.
    logic [WIDTH-1:0] g_q  [0:L];
    logic [WIDTH-1:0] p_q  [0:L];
    logic [WIDTH-1:0] pb_q [0:L];
    logic             c0_q [0:L];
    logic             v_q  [0:L];

    logic [WIDTH-1:0] g_n  [1:L];
    logic [WIDTH-1:0] p_n  [1:L];

    logic [WIDTH-1:0] b_eff;
    logic             c0;
    logic [WIDTH-1:0] p0;
    logic [WIDTH-1:0] g0;
    logic [WIDTH-1:0] sum_n;

    logic             stall;

    // One global enable: if the output is blocked, everything holds.
    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;

    // Stage 0: carry-in is folded into g[0] so the prefix tree produces
    // true carries directly.
    always_comb begin
        b_eff = sub ? ~b : b;
        c0    = sub | cin;
        p0    = a ^ b_eff;
        g0    = a & b_eff;
        g0[0] = g0[0] | (p0[0] & c0);
    end

    // Kogge-Stone prefix levels, span 2^(k-1); low bits pass through.
    always_comb begin
        for (int k = 1; k <= L; k++) begin
            g_n[k] = g_q[k-1];
            p_n[k] = p_q[k-1];
            for (int i = (1 << (k - 1)); i < WIDTH; i++) begin
                g_n[k][i] = g_q[k-1][i] | (p_q[k-1][i] & g_q[k-1][i - (1 << (k - 1))]);
                p_n[k][i] = p_q[k-1][i] & p_q[k-1][i - (1 << (k - 1))];
            end
        end
    end

    // After the last level G[i] is the carry out of bit i.
    always_comb begin
        sum_n    = pb_q[L] ^ {g_q[L][WIDTH-2:0], 1'b0};
        sum_n[0] = pb_q[L][0] ^ c0_q[L];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k <= L; k++) begin
                g_q[k]  <= '0;
                p_q[k]  <= '0;
                pb_q[k] <= '0;
                c0_q[k] <= 1'b0;
                v_q[k]  <= 1'b0;
            end
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
`ifdef KSA_PIPE_OVF_EN
            ovf       <= 1'b0;
`endif
        end else if (!stall) begin
            v_q[0]  <= in_valid;
            g_q[0]  <= g0;
            p_q[0]  <= p0;
            pb_q[0] <= p0;
            c0_q[0] <= c0;
            for (int k = 1; k <= L; k++) begin
                v_q[k]  <= v_q[k-1];
                g_q[k]  <= g_n[k];
                p_q[k]  <= p_n[k];
                pb_q[k] <= pb_q[k-1];
                c0_q[k] <= c0_q[k-1];
            end
            out_valid <= v_q[L];
            sum       <= sum_n;
            cout      <= g_q[L][WIDTH-1];
`ifdef KSA_PIPE_OVF_EN
            // Carry into MSB xor carry out of MSB.
            ovf       <= g_q[L][WIDTH-1] ^ g_q[L][WIDTH-2];
`endif
        end
    end

endmodule

// File: tb/tb_ksa_pipe.sv
// tb/tb_ksa_pipe.sv - directed self-checking bench for ksa_pipe (WIDTH=16)

module tb_ksa_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
`ifdef KSA_PIPE_OVF_EN
    logic        ovf;
`endif

    int errors = 0;
    int checks = 0;

    ksa_pipe #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef KSA_PIPE_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Presents one op at a negedge, then waits for its result. lat counts
    // rising edges from the accepting edge (1) through the edge that raises
    // out_valid. Returns at a negedge with the result visible.
    task automatic run_op(input logic [15:0] xa, input logic [15:0] xb,
                          input logic xc, input logic xs, output int lat);
        a = xa; b = xb; cin = xc; sub = xs;
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); lat = 1;
        @(negedge clk); in_valid = 1'b0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); lat++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        checks++; if (sum !== 16'h0000) begin errors++; $display("FAIL reset_sum got=%h want=0000", sum); end
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout got=%b want=0", cout); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
`ifdef KSA_PIPE_OVF_EN
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b want=0", ovf); end
`endif
        rst_n = 1'b1;
    endtask

    task automatic test_latency;
        int lat;
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, lat);
        checks++; if (lat !== 6) begin errors++; $display("FAIL latency got=%0d want=6", lat); end
        checks++; if (sum !== 16'h0000) begin errors++; $display("FAIL wrap_sum got=%h want=0000", sum); end
        checks++; if (cout !== 1'b1) begin errors++; $display("FAIL wrap_cout got=%b want=1", cout); end
`ifdef KSA_PIPE_OVF_EN
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL wrap_ovf got=%b want=0", ovf); end
`endif
        @(posedge clk); @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_no_dup got=%b want=0", out_valid); end
    endtask

    task automatic test_sub;
        int lat;
        run_op(16'h0005, 16'h0007, 1'b0, 1'b1, lat);
        checks++; if (sum !== 16'hFFFE) begin errors++; $display("FAIL sub_neg_sum got=%h want=fffe", sum); end
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL sub_neg_cout got=%b want=0", cout); end
`ifdef KSA_PIPE_OVF_EN
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL sub_neg_ovf got=%b want=0", ovf); end
`endif
        @(posedge clk); @(negedge clk);
        run_op(16'h8000, 16'h0001, 1'b0, 1'b1, lat);
        checks++; if (sum !== 16'h7FFF) begin errors++; $display("FAIL sub_ovf_sum got=%h want=7fff", sum); end
        checks++; if (cout !== 1'b1) begin errors++; $display("FAIL sub_ovf_cout got=%b want=1", cout); end
`ifdef KSA_PIPE_OVF_EN
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL sub_ovf_ovf got=%b want=1", ovf); end
`endif
        @(posedge clk); @(negedge clk);
        // cin must be ignored while subtracting
        run_op(16'h0005, 16'h0007, 1'b1, 1'b1, lat);
        checks++; if (sum !== 16'hFFFE) begin errors++; $display("FAIL sub_cin_ignored got=%h want=fffe", sum); end
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_back_to_back;
        logic [15:0] xa [0:2];
        logic [15:0] xb [0:2];
        logic        xc [0:2];
        logic [15:0] ex [0:2];
        int          wait_cnt;
        xa[0] = 16'h0001; xb[0] = 16'h0002; xc[0] = 1'b0; ex[0] = 16'h0003;
        xa[1] = 16'h0003; xb[1] = 16'h0004; xc[1] = 1'b0; ex[1] = 16'h0007;
        xa[2] = 16'h00FF; xb[2] = 16'h0001; xc[2] = 1'b1; ex[2] = 16'h0101;
        out_ready = 1'b1; sub = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a = xa[i]; b = xb[i]; cin = xc[i]; in_valid = 1'b1;
            @(posedge clk); @(negedge clk);
        end
        in_valid = 1'b0;
        wait_cnt = 0;
        while (!out_valid && wait_cnt < 20) begin
            @(posedge clk); @(negedge clk); wait_cnt++;
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_valid !== 1'b1 || sum !== ex[i]) begin
                errors++;
                $display("FAIL b2b_%0d got valid=%b sum=%h want valid=1 sum=%h", i, out_valid, sum, ex[i]);
            end
            @(posedge clk); @(negedge clk);
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_no_extra got=%b want=0", out_valid); end
    endtask

    task automatic test_stall;
        logic [15:0] xa [0:6];
        logic [15:0] xb [0:6];
        logic        xc [0:6];
        logic [15:0] ex [0:6];
        int          idx;
        for (int i = 0; i < 7; i++) begin
            xa[i] = 16'(16'h1111 * (i + 1));
            xb[i] = 16'(16'h0F0F + i);
            xc[i] = 1'(i & 1);
            ex[i] = 16'(xa[i] + xb[i] + 16'(xc[i]));
        end
        out_ready = 1'b0; sub = 1'b0;
        // Six accepts fill all six stages before out_valid rises.
        for (int i = 0; i < 6; i++) begin
            a = xa[i]; b = xb[i]; cin = xc[i]; in_valid = 1'b1;
            @(posedge clk); @(negedge clk);
        end
        a = xa[6]; b = xb[6]; cin = xc[6]; in_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready_%0d got=%b want=0", c, in_ready); end
            checks++;
            if (out_valid !== 1'b1 || sum !== ex[0]) begin
                errors++;
                $display("FAIL stall_hold_%0d got valid=%b sum=%h want valid=1 sum=%h", c, out_valid, sum, ex[0]);
            end
            @(posedge clk); @(negedge clk);
        end
        out_ready = 1'b1;
        idx = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (out_valid) begin
                checks++;
                if (idx >= 7) begin
                    errors++;
                    $display("FAIL stall_extra got=%h want=none", sum);
                end else if (sum !== ex[idx]) begin
                    errors++;
                    $display("FAIL stall_order_%0d got=%h want=%h", idx, sum, ex[idx]);
                end
                idx++;
            end
            @(posedge clk); @(negedge clk);
            in_valid = 1'b0;
        end
        checks++; if (idx !== 7) begin errors++; $display("FAIL stall_count got=%0d want=7", idx); end
    endtask

    task automatic test_reset_inflight;
        int wait_cnt;
        int stale;
        int lat;
        out_ready = 1'b0; sub = 1'b0; cin = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a = 16'(16'h0100 * (i + 1)); b = 16'h0001; in_valid = 1'b1;
            @(posedge clk); @(negedge clk);
        end
        in_valid = 1'b0;
        wait_cnt = 0;
        while (!out_valid && wait_cnt < 20) begin
            @(posedge clk); @(negedge clk); wait_cnt++;
        end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL inflight_pre got=%b want=1", out_valid); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL async_reset_valid got=%b want=0", out_valid); end
        checks++; if (sum !== 16'h0000) begin errors++; $display("FAIL async_reset_sum got=%h want=0000", sum); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL async_reset_in_ready got=%b want=1", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        // First edge after release accepts; stale data would shorten latency.
        run_op(16'h1234, 16'h1111, 1'b0, 1'b0, lat);
        checks++; if (lat !== 6) begin errors++; $display("FAIL post_reset_latency got=%0d want=6", lat); end
        checks++; if (sum !== 16'h2345) begin errors++; $display("FAIL post_reset_sum got=%h want=2345", sum); end
        stale = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); @(negedge clk);
            if (out_valid) stale++;
        end
        checks++; if (stale !== 0) begin errors++; $display("FAIL post_reset_stale got=%0d want=0", stale); end
    endtask

`ifdef KSA_PIPE_OVF_EN
    task automatic test_ovf;
        int lat;
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, lat);
        checks++; if (sum !== 16'h8000) begin errors++; $display("FAIL ovf_sum got=%h want=8000", sum); end
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%b want=1", ovf); end
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL ovf_cout got=%b want=0", cout); end
        @(posedge clk); @(negedge clk);
    endtask
`endif

    initial begin
        test_reset;
        test_latency;
        test_sub;
        test_back_to_back;
        test_stall;
        test_reset_inflight;
`ifdef KSA_PIPE_OVF_EN
        test_ovf;
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
